// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory-access unit: FSM states, default MMIO
// addresses and status-register bit positions.
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;
  localparam logic [15:0] DSR_ADDR_DEF  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR_DEF  = 16'hFE06;

  localparam int unsigned KBSR_READY = 15;
  localparam int unsigned KBSR_IE    = 14;
  localparam int unsigned KBSR_OVR   = 13;
  localparam int unsigned DSR_READY  = 15;

  localparam int unsigned KB_CHAR_W  = 8;

endpackage

// File: rtl/lc3_kbd_if.sv
// Keyboard receive register: one-character buffer with full/overrun flags and
// the interrupt-enable bit written through KBSR.
module lc3_kbd_if
  import lc3_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 strobe_i,
  input  logic [KB_CHAR_W-1:0] char_i,
  input  logic                 rd_i,
  input  logic                 ie_we_i,
  input  logic                 ie_wdata_i,
  output logic [KB_CHAR_W-1:0] data_o,
  output logic                 full_o,
  output logic                 ovr_o,
  output logic                 ie_o
);

  logic [KB_CHAR_W-1:0] data_q, data_d;
  logic                 full_q, full_d;
  logic                 ovr_q,  ovr_d;
  logic                 ie_q,   ie_d;

  // A read frees the buffer, so a strobe landing on the same edge always loads.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    ovr_d  = ovr_q;
    ie_d   = ie_q;
    if (rd_i) begin
      ovr_d  = 1'b0;
      full_d = strobe_i;
      if (strobe_i) data_d = char_i;
    end else if (strobe_i) begin
      if (full_q) begin
        ovr_d = 1'b1;
      end else begin
        data_d = char_i;
        full_d = 1'b1;
      end
    end
    if (ie_we_i) ie_d = ie_wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      full_q <= 1'b0;
      ovr_q  <= 1'b0;
      ie_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      ovr_q  <= ovr_d;
      ie_q   <= ie_d;
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;
  assign ovr_o  = ovr_q;
  assign ie_o   = ie_q;

endmodule

// File: rtl/lc3_mem_unit.sv
// LC-3 memory-access unit: MAR/MDR, R handshake to the control FSM, a
// variable-latency memory port and keyboard/display memory-mapped I/O.
module lc3_mem_unit
  import lc3_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter logic [15:0] KBSR_ADDR = KBSR_ADDR_DEF,
  parameter logic [15:0] KBDR_ADDR = KBDR_ADDR_DEF,
  parameter logic [15:0] DSR_ADDR  = DSR_ADDR_DEF,
  parameter logic [15:0] DDR_ADDR  = DDR_ADDR_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] BUS_IN,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              MIO_EN,
  input  logic              R_W,
  output logic              R,
  output logic [ADDR_W-1:0] MAR_OUT,
  output logic [DATA_W-1:0] MDR_OUT,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  input  logic              KB_STROBE,
  input  logic [7:0]        KB_CHAR,
  input  logic              DISP_READY,
  output logic              DISP_VALID,
  output logic [7:0]        DISP_DATA,
  output logic              INT_REQ
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mar_q, mar_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic                disp_valid_q, disp_valid_d;
  logic [7:0]          disp_data_q, disp_data_d;

  logic                hit_kbsr, hit_kbdr, hit_dsr, hit_ddr, io_hit;
  logic                io_go;
  logic                kb_rd, kb_ie_we;
  logic [KB_CHAR_W-1:0] kb_data;
  logic                kb_full, kb_ovr, kb_ie;
  logic [15:0]         kbsr_v, dsr_v;
  logic [DATA_W-1:0]   io_rdata;

  assign hit_kbsr = (mar_q == ADDR_W'(KBSR_ADDR));
  assign hit_kbdr = (mar_q == ADDR_W'(KBDR_ADDR));
  assign hit_dsr  = (mar_q == ADDR_W'(DSR_ADDR));
  assign hit_ddr  = (mar_q == ADDR_W'(DDR_ADDR));
  assign io_hit   = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;

  // I/O read mux; DDR and unmapped addresses read as zero.
  always_comb begin
    kbsr_v             = '0;
    kbsr_v[KBSR_READY] = kb_full;
    kbsr_v[KBSR_IE]    = kb_ie;
    kbsr_v[KBSR_OVR]   = kb_ovr;
    dsr_v              = '0;
    dsr_v[DSR_READY]   = DISP_READY;
    io_rdata           = '0;
    if (hit_kbsr)      io_rdata = DATA_W'(kbsr_v);
    else if (hit_kbdr) io_rdata = DATA_W'(kb_data);
    else if (hit_dsr)  io_rdata = DATA_W'(dsr_v);
  end

  // Access sequencer; I/O accesses complete on the edge leaving IDLE.
  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    io_go   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (MIO_EN) begin
          if (io_hit) begin
            state_d = ST_DONE;
            rbuf_d  = io_rdata;
            io_go   = 1'b1;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        if (MEM_ACK) begin
          state_d = ST_DONE;
          rbuf_d  = MEM_RDATA;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign kb_rd    = io_go & hit_kbdr & ~R_W;
  assign kb_ie_we = io_go & hit_kbsr & R_W;

  always_comb begin
    mar_d        = LD_MAR ? ADDR_W'(BUS_IN) : mar_q;
    mdr_d        = mdr_q;
    if (state_q == ST_DONE) begin
      if (LD_MDR && !R_W) mdr_d = rbuf_q;
    end else if (!MIO_EN && LD_MDR) begin
      mdr_d = BUS_IN;
    end
    disp_valid_d = io_go & hit_ddr & R_W & DISP_READY;
    disp_data_d  = disp_valid_d ? mdr_q[7:0] : disp_data_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      mar_q        <= '0;
      mdr_q        <= '0;
      rbuf_q       <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      rbuf_q       <= rbuf_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
    end
  end

  lc3_kbd_if u_kbd (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .strobe_i   (KB_STROBE),
    .char_i     (KB_CHAR),
    .rd_i       (kb_rd),
    .ie_we_i    (kb_ie_we),
    .ie_wdata_i (mdr_q[KBSR_IE]),
    .data_o     (kb_data),
    .full_o     (kb_full),
    .ovr_o      (kb_ovr),
    .ie_o       (kb_ie)
  );

  assign R          = (state_q == ST_DONE);
  assign MEM_REQ    = (state_q == ST_MEM);
  assign MEM_WE     = (state_q == ST_MEM) & R_W;
  assign MAR_OUT    = mar_q;
  assign MDR_OUT    = mdr_q;
  assign MEM_ADDR   = mar_q;
  assign MEM_WDATA  = mdr_q;
  assign DISP_VALID = disp_valid_q;
  assign DISP_DATA  = disp_data_q;
  assign INT_REQ    = kb_full & kb_ie;

endmodule
